// File: rtl/alu4_pkg.sv
// ------------------------------------------------------------------
// alu4_pkg: shared op encodings and sequencer state type for alu4
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package alu4_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_INC  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu4.sv
// ------------------------------------------------------------------
// alu4: combinational 4-bit ALU, all arithmetic modulo 16
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_sel,
  output logic [3:0] o_y
);
  import alu4_pkg::*;

  always_comb begin
    o_y = i_a + i_b;
    case (i_sel)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_NOT:  o_y = ~i_a;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_LOAD: o_y = i_b;
      OP_INC:  o_y = i_a + 4'd1;
      default: o_y = i_a + i_b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu4_acc_seq.sv
// ------------------------------------------------------------------
// alu4_acc_seq: valid/ready accumulator sequencer driving one alu4
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu4_acc_seq #(
  parameter  int MAX_OPS = 15,
  localparam int CW      = $clog2(MAX_OPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [3:0]    cmd_operand,
  input  logic          cmd_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_acc,
  output logic          res_zero,
  output logic [CW-1:0] res_count,
  output logic          res_trunc,
  output logic          busy
);
  import alu4_pkg::*;

  state_t        r_state;
  logic [3:0]    r_acc;
  logic [CW-1:0] r_count;
  logic          r_res_valid;
  logic [3:0]    r_res_acc;
  logic          r_res_zero;
  logic [CW-1:0] r_res_count;
  logic          r_res_trunc;

  logic          w_accept;
  logic          w_end;
  logic [3:0]    w_alu_a;
  logic [3:0]    w_alu_y;
  logic [CW-1:0] w_next_count;

  assign cmd_ready    = (r_state != RESP);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_alu_a      = (r_state == IDLE) ? 4'h0 : r_acc;
  assign w_next_count = (r_state == IDLE) ? CW'(1) : r_count + CW'(1);
  // The op limit also covers MAX_OPS==1 from IDLE, since next count is 1 there.
  assign w_end        = cmd_last || (w_next_count == CW'(MAX_OPS));

  alu4 u_alu (
    .i_a   (w_alu_a),
    .i_b   (cmd_operand),
    .i_sel (cmd_op),
    .o_y   (w_alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 4'h0;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_res_acc   <= 4'h0;
      r_res_zero  <= 1'b0;
      r_res_count <= '0;
      r_res_trunc <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_alu_y;
            r_count <= w_next_count;
            if (w_end) begin
              r_state     <= RESP;
              r_res_valid <= 1'b1;
              r_res_acc   <= w_alu_y;
              r_res_zero  <= (w_alu_y == 4'h0);
              r_res_count <= w_next_count;
              r_res_trunc <= !cmd_last;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        RESP: begin
          if (res_ready) begin
            r_state     <= IDLE;
            r_acc       <= 4'h0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_acc   = r_res_acc;
  assign res_zero  = r_res_zero;
  assign res_count = r_res_count;
  assign res_trunc = r_res_trunc;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu4_acc_seq.sv
// ------------------------------------------------------------------
// tb_alu4_acc_seq: scoreboard bench for the default and MAX_OPS=4 builds
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_alu4_acc_seq;
  import alu4_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_last = 1'b0;
  logic       res_ready = 1'b1;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] cmd_operand = 4'h0;

  logic       rdy1, rv1, rz1, rt1, busy1;
  logic [3:0] racc1;
  logic [3:0] rc1;
  logic       rdy2, rv2, rz2, rt2, busy2;
  logic [3:0] racc2;
  logic [2:0] rc2;

  logic       rdy, rv, rz, rt, bsy;
  logic [3:0] racc;
  logic [7:0] rc;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] acc;
    logic       zero;
    logic [7:0] count;
    logic       trunc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  alu4_acc_seq u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_last(cmd_last),
    .res_valid(rv1), .res_ready(res_ready), .res_acc(racc1), .res_zero(rz1),
    .res_count(rc1), .res_trunc(rt1), .busy(busy1)
  );

  alu4_acc_seq #(.MAX_OPS(4)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(rdy2),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_last(cmd_last),
    .res_valid(rv2), .res_ready(res_ready), .res_acc(racc2), .res_zero(rz2),
    .res_count(rc2), .res_trunc(rt2), .busy(busy2)
  );

  assign rdy  = sel ? rdy2  : rdy1;
  assign rv   = sel ? rv2   : rv1;
  assign rz   = sel ? rz2   : rz1;
  assign rt   = sel ? rt2   : rt1;
  assign bsy  = sel ? busy2 : busy1;
  assign racc = sel ? racc2 : racc1;
  assign rc   = sel ? {5'b0, rc2} : {4'b0, rc1};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic z, input logic [7:0] c, input logic t);
    exp_t e;
    e.acc = a; e.zero = z; e.count = c; e.trunc = t;
    if (sel) q2.push_back(e);
    else     q1.push_back(e);
  endtask

  // Holds the command until it is accepted; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [3:0] b, input logic last);
    logic seen;
    seen = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = b; cmd_last = last;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = rdy;
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 40 cycles");
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    cmd_last = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rv1 && res_ready) begin
        if (q1.size() == 0) begin
          check("sb1_unexpected_result", 8'd1, 8'd0);
        end else begin
          e = q1.pop_front();
          check("sb1_acc",   {4'b0, racc1}, {4'b0, e.acc});
          check("sb1_zero",  {7'b0, rz1},   {7'b0, e.zero});
          check("sb1_count", {4'b0, rc1},   e.count);
          check("sb1_trunc", {7'b0, rt1},   {7'b0, e.trunc});
        end
      end
    end
  end

  initial begin : mon2
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rv2 && res_ready) begin
        if (q2.size() == 0) begin
          check("sb2_unexpected_result", 8'd1, 8'd0);
        end else begin
          e = q2.pop_front();
          check("sb2_acc",   {4'b0, racc2}, {4'b0, e.acc});
          check("sb2_zero",  {7'b0, rz2},   {7'b0, e.zero});
          check("sb2_count", {5'b0, rc2},   e.count);
          check("sb2_trunc", {7'b0, rt2},   {7'b0, e.trunc});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid1", {7'b0, rv1},   8'd0);
    check("rst_busy1",  {7'b0, busy1}, 8'd0);
    check("rst_ready1", {7'b0, rdy1},  8'd1);
    check("rst_acc1",   {4'b0, racc1}, 8'd0);
    check("rst_zero1",  {7'b0, rz1},   8'd0);
    check("rst_count1", {4'b0, rc1},   8'd0);
    check("rst_trunc1", {7'b0, rt1},   8'd0);
    check("rst_valid2", {7'b0, rv2},   8'd0);
    check("rst_busy2",  {7'b0, busy2}, 8'd0);
    rst = 1'b0;
    idle(1);

    // add chain, back to back
    push(4'h6, 1'b0, 8'd3, 1'b0);
    send(OP_ADD, 4'h3, 1'b0);
    send(OP_ADD, 4'h5, 1'b0);
    check("t1_busy_mid",  {7'b0, bsy}, 8'd1);
    check("t1_valid_mid", {7'b0, rv},  8'd0);
    send(OP_SUB, 4'h2, 1'b1);
    check("t1_latency", {7'b0, rv}, 8'd1);
    idle(2);

    // wrap to zero
    push(4'h0, 1'b1, 8'd2, 1'b0);
    send(OP_LOAD, 4'hF, 1'b0);
    send(OP_INC,  4'h0, 1'b1);
    check("t2_latency", {7'b0, rv}, 8'd1);
    idle(2);

    // logic ops: A -> 2 -> B -> 4 -> B
    push(4'hB, 1'b0, 8'd5, 1'b0);
    send(OP_LOAD, 4'hA, 1'b0);
    send(OP_AND,  4'h6, 1'b0);
    send(OP_OR,   4'h9, 1'b0);
    send(OP_XOR,  4'hF, 1'b0);
    send(OP_NOT,  4'h0, 1'b1);
    check("t3_latency", {7'b0, rv}, 8'd1);
    idle(2);

    // result backpressure with a command waiting
    res_ready = 1'b0;
    push(4'h9, 1'b0, 8'd1, 1'b0);
    send(OP_LOAD, 4'h9, 1'b1);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_operand = 4'h1; cmd_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_ready_low", {7'b0, rdy}, 8'd0);
      check("t4_valid_hold", {7'b0, rv}, 8'd1);
      check("t4_acc_hold", {4'b0, racc}, 8'h09);
      check("t4_count_hold", rc, 8'd1);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    push(4'h1, 1'b0, 8'd1, 1'b0);
    send(OP_ADD, 4'h1, 1'b1);
    check("t4_latency", {7'b0, rv}, 8'd1);
    idle(2);

    // MAX_OPS=4 truncation, leftover commands stay pending
    sel = 1'b1;
    idle(1);
    push(4'h4, 1'b0, 8'd4, 1'b1);
    for (int i = 0; i < 4; i++) send(OP_ADD, 4'h1, 1'b0);
    check("t5_latency", {7'b0, rv}, 8'd1);
    send(OP_ADD, 4'h1, 1'b0);
    send(OP_ADD, 4'h1, 1'b0);
    idle(3);
    check("t5_pending_valid", {7'b0, rv},  8'd0);
    check("t5_pending_busy",  {7'b0, bsy}, 8'd1);
    check("t5_pending_ready", {7'b0, rdy}, 8'd1);
    push(4'h3, 1'b0, 8'd3, 1'b0);
    send(OP_ADD, 4'h1, 1'b1);
    check("t5b_latency", {7'b0, rv}, 8'd1);
    idle(2);

    // last on the limiting command is not a truncation
    push(4'h8, 1'b0, 8'd4, 1'b0);
    send(OP_ADD, 4'h2, 1'b0);
    send(OP_ADD, 4'h2, 1'b0);
    send(OP_ADD, 4'h2, 1'b0);
    send(OP_ADD, 4'h2, 1'b1);
    check("t5c_latency", {7'b0, rv}, 8'd1);
    idle(2);

    // reset mid-transaction discards progress
    sel = 1'b0;
    idle(1);
    send(OP_ADD, 4'h2, 1'b0);
    send(OP_ADD, 4'h3, 1'b0);
    cmd_valid = 1'b0;
    cmd_last = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_valid", {7'b0, rv1},   8'd0);
    check("t6_busy",  {7'b0, busy1}, 8'd0);
    check("t6_ready", {7'b0, rdy1},  8'd1);
    check("t6_acc",   {4'b0, racc1}, 8'd0);
    check("t6_zero",  {7'b0, rz1},   8'd0);
    check("t6_count", {4'b0, rc1},   8'd0);
    check("t6_trunc", {7'b0, rt1},   8'd0);
    idle(2);
    check("t6_valid_after", {7'b0, rv1}, 8'd0);
    push(4'h7, 1'b0, 8'd1, 1'b0);
    send(OP_ADD, 4'h7, 1'b1);
    check("t6_latency", {7'b0, rv}, 8'd1);
    idle(2);

    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    check("sb_drained", 8'(q1.size() + q2.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
